// File: rtl/or_gate_lab1_st.sv
// ---------------------------------------------------------------------------
// or_gate_lab1_st
// Purpose: a gate-level bitwise two-input OR with a clocked observation side
//          path. The side path registers the OR result and keeps a saturating
//          count of cycles in which any output bit was high.
//
// Parameters:
//   WIDTH    - bit width of a, b, c and c_q (OR is applied per bit)
//   CNT_W    - width of hi_count
//
// Ports (declaration order lets the positional form (a, b, c) bind the gate):
//   a        in  [WIDTH]  OR operand A
//   b        in  [WIDTH]  OR operand B
//   c        out [WIDTH]  a | b, built from one or-primitive per bit
//   clk      in  1        rising-edge clock, registered path only
//   rst      in  1        synchronous active-high reset, registered path only
//   c_q      out [WIDTH]  c sampled at the previous rising edge
//   c_any    out 1        reduction OR of c, combinational
//   hi_count out [CNT_W]  saturating count of edges that sampled c_any = 1
// ---------------------------------------------------------------------------
module or_gate_lab1_st #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output wire  [WIDTH-1:0] c,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] c_q,
    output logic             c_any,
    output logic [CNT_W-1:0] hi_count
);

    // Saturation ceiling of the cycle counter.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_c_q;
    logic [CNT_W-1:0] r_hi_count;
    logic             w_c_any;
    logic             w_cnt_en;

    // Gate-level core: c stays usable with clk/rst left unconnected.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_or
        or u_or (c[gi], a[gi], b[gi]);
    end

    // Any-bit-high indicator, follows the gate outputs with no clocking.
    assign w_c_any = |c;

    // Count only while below the ceiling so the counter never wraps.
    assign w_cnt_en = w_c_any && (r_hi_count != CNT_MAX);

    // Observation registers; reset drops any increment pending on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q      <= '0;
            r_hi_count <= '0;
        end else begin
            r_c_q <= c;
            if (w_cnt_en) begin
                r_hi_count <= r_hi_count + CNT_W'(1);
            end
        end
    end

    assign c_q      = r_c_q;
    assign c_any    = w_c_any;
    assign hi_count = r_hi_count;

endmodule

// File: tb/tb_or_gate_lab1_st.sv
module tb_or_gate_lab1_st;

    // Signal selectors for scoreboard entries.
    localparam int ID_C1    = 0;
    localparam int ID_CQ1   = 1;
    localparam int ID_CNT1  = 2;
    localparam int ID_CANY1 = 3;
    localparam int ID_CNT3  = 4;
    localparam int ID_C4    = 5;
    localparam int ID_CANY4 = 6;

    typedef struct {
        int         id;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    logic rst;

    // DUT 1: WIDTH=1, CNT_W=8
    logic       a1, b1;
    wire        c1;
    logic       cq1, cany1;
    logic [7:0] cnt1;

    // DUT 3: WIDTH=1, CNT_W=3 (saturation)
    logic       a3, b3;
    wire        c3;
    logic       cq3, cany3;
    logic [2:0] cnt3;

    // DUT 4: WIDTH=4, CNT_W=8 (wide vector)
    logic [3:0] a4, b4;
    wire  [3:0] c4;
    logic [3:0] cq4;
    logic       cany4;
    logic [7:0] cnt4;

    always #5 clk = ~clk;

    or_gate_lab1_st #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .a(a1), .b(b1), .c(c1), .clk(clk), .rst(rst),
        .c_q(cq1), .c_any(cany1), .hi_count(cnt1)
    );

    or_gate_lab1_st #(.WIDTH(1), .CNT_W(3)) u_dut3 (
        .a(a3), .b(b3), .c(c3), .clk(clk), .rst(rst),
        .c_q(cq3), .c_any(cany3), .hi_count(cnt3)
    );

    or_gate_lab1_st #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .a(a4), .b(b4), .c(c4), .clk(clk), .rst(rst),
        .c_q(cq4), .c_any(cany4), .hi_count(cnt4)
    );

    function automatic logic [7:0] actual(input int id);
        case (id)
            ID_C1:    return {7'd0, c1};
            ID_CQ1:   return {7'd0, cq1};
            ID_CNT1:  return cnt1;
            ID_CANY1: return {7'd0, cany1};
            ID_CNT3:  return {5'd0, cnt3};
            ID_C4:    return {4'd0, c4};
            ID_CANY4: return {7'd0, cany4};
            default:  return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(input int id, input logic [7:0] exp, input string name);
        exp_t e;
        e.id   = id;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Advance one edge; inputs are driven 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every pending expectation mid-cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sbq.pop_front();
            act = actual(e.id);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a3 = 1'b0; b3 = 1'b0;
        a4 = 4'd0; b4 = 4'd0;

        // Reset for two edges.
        step();
        step();
        expect_val(ID_CQ1,  8'd0, "reset_cq");
        expect_val(ID_CNT1, 8'd0, "reset_cnt");
        expect_val(ID_CNT3, 8'd0, "reset_cnt3");

        // Truth table, held in reset to show rst leaves c alone.
        a1 = 1'b0; b1 = 1'b0;
        expect_val(ID_C1, 8'd0, "tt_00"); expect_val(ID_CANY1, 8'd0, "tt_any_00");
        step();
        a1 = 1'b0; b1 = 1'b1;
        expect_val(ID_C1, 8'd1, "tt_01"); expect_val(ID_CANY1, 8'd1, "tt_any_01");
        step();
        a1 = 1'b1; b1 = 1'b0;
        expect_val(ID_C1, 8'd1, "tt_10");
        step();
        a1 = 1'b1; b1 = 1'b1;
        expect_val(ID_C1, 8'd1, "tt_11");
        expect_val(ID_CNT1, 8'd0, "tt_cnt_in_reset");
        step();

        // Registered path.
        a1 = 1'b0; b1 = 1'b0;
        step();
        rst = 1'b0;
        a1  = 1'b1;
        expect_val(ID_CQ1, 8'd0, "reg_before_edge");
        step();
        expect_val(ID_CQ1,  8'd1, "reg_one_edge");
        expect_val(ID_CNT1, 8'd1, "reg_cnt");
        a1 = 1'b0;
        expect_val(ID_C1, 8'd0, "reg_c_drop");
        step();
        expect_val(ID_CQ1,  8'd0, "reg_back_low");
        expect_val(ID_CNT1, 8'd1, "reg_cnt_hold");

        // Counter: 5 edges high, then 3 edges low.
        rst = 1'b1;
        step();
        rst = 1'b0;
        a1  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            expect_val(ID_CNT1, 8'(k), "cnt_up");
        end
        a1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_val(ID_CNT1, 8'd5, "cnt_hold");
        end

        // Reset mid-count.
        rst = 1'b1;
        step();
        rst = 1'b0;
        a1  = 1'b1;
        for (int k = 0; k < 3; k++) step();
        expect_val(ID_CNT1, 8'd3, "mid_pre");
        rst = 1'b1;
        expect_val(ID_C1, 8'd1, "mid_c_pre");
        step();
        expect_val(ID_CNT1, 8'd0, "mid_cnt_clr");
        expect_val(ID_CQ1,  8'd0, "mid_cq_clr");
        expect_val(ID_C1,   8'd1, "mid_c_hold");
        rst = 1'b0;
        step();
        expect_val(ID_CNT1, 8'd1, "mid_resume");
        expect_val(ID_CQ1,  8'd1, "mid_cq_resume");
        a1 = 1'b0;

        // Saturation at CNT_W=3.
        b3 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_val(ID_CNT3, (k < 7) ? 8'(k) : 8'd7, "sat");
        end
        b3 = 1'b0;

        // Wide vector.
        a4 = 4'b1010;
        b4 = 4'b0001;
        expect_val(ID_C4,    8'h0b, "wide_c");
        expect_val(ID_CANY4, 8'd1,  "wide_any");
        step();
        a4 = 4'b0000;
        b4 = 4'b0000;
        expect_val(ID_C4,    8'h00, "wide_c_zero");
        expect_val(ID_CANY4, 8'd0,  "wide_any_zero");

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
